fifo_arb_ctrl: RTL

FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 31 +++
 rtl/fifo_arb_ctrl_rr_arbiter.sv | 39 +++
 rtl/fifo_arb_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the FIFO arbiter/controller slice:
//   - fsm_state_t   : controller FSM states (INIT, RUN, FLUSH)
//   - DEF_*         : default parameter values for fifo_arb_ctrl
//   - ptr_width()   : width of a round-robin pointer for N requesters
//   - sat_inc16()   : saturating 16-bit increment for statistics counters
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fsm_state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_FIFO_DEPTH  = 16;
   localparam int DEF_FIFO_WIDTH  = 8;
   localparam int DEF_FIFO_CNTR_W = 5;

   // A single requester still needs a 1-bit pointer to keep port widths legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fifo_arb_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Pure combinational round-robin selector. Searches upward from ptr_i,
// wrapping at NUM_REQ; the first requesting index wins.
// Ports:
//   req_i     [NUM_REQ-1:0] : request vector
//   ptr_i     [PTR_W-1:0]   : current search start index
//   gnt_o     [NUM_REQ-1:0] : one-hot grant (all zero when no request)
//   ptr_nxt_o [PTR_W-1:0]   : (winner+1) mod NUM_REQ, or ptr_i when no winner
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   ptr_nxt_o
);

   always_comb begin
      int   idx;
      logic found;
      gnt_o     = '0;
      ptr_nxt_o = ptr_i;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // modulo also folds pointer values beyond NUM_REQ-1 back into range
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_nxt_o  = PTR_W'((idx + 1) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_arb_ctrl
// Controller sitting in front of an external FIFO: arbitrates NUM_REQ
// producers round-robin onto the FIFO write side, accepts consumer reads,
// tracks occupancy, and sequences pointer reset / flush.
//
// Ports:
//   clk           : single clock, rising edge
//   FIFO_reset    : synchronous active-high reset
//   req/req_data  : per-producer push request and word (slice i = [i*W +: W])
//   gnt           : one-hot grant; granted word is written this cycle
//   pop_req       : consumer read request
//   pop_ack       : read accepted; FIFO data_out valid this cycle
//   flush         : discard all FIFO contents
//   push/pop      : FIFO strobes
//   data_in       : word to FIFO (0 when no grant)
//   FIFO_reset_n  : active-low FIFO pointer reset (low in INIT/FLUSH)
//   count/full/empty : occupancy status
//   drop_cnt      : only with FIFO_ARB_STATS_EN defined; saturating count of
//                   RUN cycles with a request but no grant
//
// Optional feature macro: FIFO_ARB_STATS_EN
// -----------------------------------------------------------------------------
module fifo_arb_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int FIFO_depth  = DEF_FIFO_DEPTH,
   parameter int FIFO_width  = DEF_FIFO_WIDTH,
   parameter int FIFO_cntr_w = DEF_FIFO_CNTR_W
) (
   input  logic                          clk,
   input  logic                          FIFO_reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_width-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          pop_req,
   output logic                          pop_ack,
   input  logic                          flush,
   output logic                          push,
   output logic                          pop,
   output logic [FIFO_width-1:0]         data_in,
   output logic                          FIFO_reset_n,
   output logic [FIFO_cntr_w-1:0]        count,
   output logic                          full,
   output logic                          empty
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [15:0]                   drop_cnt
`endif
);

   localparam int PTR_W = ptr_width(NUM_REQ);
   localparam logic [FIFO_cntr_w-1:0] DEPTH_C = FIFO_cntr_w'(FIFO_depth);

   fsm_state_t             state_q, state_d;
   logic [FIFO_cntr_w-1:0] count_q, count_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]     arb_gnt;
   logic [PTR_W-1:0]       arb_ptr_nxt;
   logic                   run;
   logic                   gnt_en;

   // Gating with FIFO_reset keeps outputs quiet from the very first reset
   // cycle, before the synchronous reset has reached the state register.
   assign run = (state_q == ST_RUN) && !FIFO_reset;

   assign FIFO_reset_n = run;
   assign count        = FIFO_reset ? '0 : count_q;
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_C);

   // flush wins over both read and write in the cycle it is seen
   assign pop_ack = pop_req && !empty && run && !flush;
   assign pop     = pop_ack;

   // When full, a simultaneous read frees the slot being written.
   assign gnt_en = run && !flush && (!full || pop_ack);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req_i     (req),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (arb_gnt),
      .ptr_nxt_o (arb_ptr_nxt)
   );

   assign gnt  = gnt_en ? arb_gnt : '0;
   assign push = |gnt;

   always_comb begin
      data_in = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            data_in = data_in | req_data[i*FIFO_width +: FIFO_width];
         end
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT:  state_d = ST_RUN;
         ST_RUN:   state_d = flush ? ST_FLUSH : ST_RUN;
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_INIT;
      endcase
   end

   // Occupancy and pointer next state. Count is cleared on the flush edge so
   // that it already reads 0 during the FLUSH cycle.
   always_comb begin
      count_d  = count_q;
      rr_ptr_d = push ? arb_ptr_nxt : rr_ptr_q;
      if (state_q != ST_RUN || flush) begin
         count_d = '0;
      end else if (push && !pop && count_q != DEPTH_C) begin
         count_d = count_q + FIFO_cntr_w'(1);
      end else if (pop && !push && count_q != '0) begin
         count_d = count_q - FIFO_cntr_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (FIFO_reset) begin
         state_q  <= ST_INIT;
         count_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (state_q != ST_RUN) begin
         drop_d = '0;
      end else if (|req && !push) begin
         drop_d = sat_inc16(drop_q);
      end
   end

   always_ff @(posedge clk) begin
      if (FIFO_reset) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = FIFO_reset ? '0 : drop_q;
`endif

endmodule
